// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and its tick generator.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;

    localparam int unsigned OVERSAMPLE        = 16;
    localparam int unsigned START_SAMPLE      = 7;
    localparam int unsigned BIT_SAMPLE        = 15;
    localparam int unsigned DATA_BITS_DEFAULT = 8;

    // Clocks per 16x sample tick; callers must keep the result >= 2.
    function automatic int unsigned tickDiv(input int unsigned clockRate,
                                            input int unsigned baudRate);
        return clockRate / (baudRate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Single-cycle 16x-oversample strobe derived from the board clock.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 19200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV   = tickDiv(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (count == CNT_W'(DIV - 1))) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampled, valid/ack holding register, framing and overrun pulses.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    logic                 rxMeta;
    logic                 rxS;
    logic                 rxQ;
    logic                 tick;
    logic                 startDet;
    rxState_e             state;
    logic [3:0]           sampleCnt;
    logic [IDX_W-1:0]     bitIdx;
    logic [DATA_BITS-1:0] shiftReg;

    // Two-flop synchronizer plus edge-detect history, all idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxQ    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
            rxQ    <= rxS;
        end
    end

    assign startDet = (state == IDLE) && rxQ && !rxS;

    uart_rx_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (startDet),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (startDet) begin
                        state     <= START;
                        sampleCnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sampleCnt == 4'(START_SAMPLE)) begin
                            if (rxS) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                sampleCnt <= '0;
                                bitIdx    <= '0;
                                state     <= DATA;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sampleCnt <= sampleCnt + 4'd1;
                        if (sampleCnt == 4'(BIT_SAMPLE)) begin
                            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                            bitIdx   <= bitIdx + IDX_W'(1);
                            if (bitIdx == IDX_W'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sampleCnt <= sampleCnt + 4'd1;
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        if (sampleCnt == 4'(BIT_SAMPLE)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (rxS) begin
                                rx_data  <= shiftReg;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rx_ack) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver for 8N1 serial frames, LSB first, using 16x oversampling.
- Counterpart to the baud-rate generator. It consumes the same CLOCK_RATE/BAUD_RATE pair but derives its own single-cycle 16x sample strobe, so everything runs on one clock domain.
- Delivers each received byte through a valid/ack holding register and reports framing and overrun errors.
- Sits between the board RX pin and the command/data path that consumes bytes.

Parameters:
- CLOCK_RATE, 12000000: board clock in Hz.
- BAUD_RATE, 19200: serial bit rate.
- DATA_BITS, 8: payload bits per frame.
- Derived constant DIV = CLOCK_RATE/(BAUD_RATE*16), integer division, must be >= 2. At the defaults DIV = 39.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- rx_data  out  DATA_BITS  last good byte, held stable while rx_valid=1.
- rx_valid  out  1  level; byte available.
- rx_ack  in  1  consumer accepts the byte; clears rx_valid.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- overrun  out  1  one-cycle pulse; a new byte landed while rx_valid=1 with no ack.
- busy  out  1  high whenever state != IDLE.

Behaviour:

Reset (asynchronous):
- Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Internals: state=IDLE; both synchronizer flops and the edge-detect flop =1; tick counter and sample counter =0; bit index =0; shift register =0.
- Reset asserted mid-frame discards the partial frame. No output pulses are generated.

Input conditioning:
- Two-flop synchronizer gives rx_s.
- Previous-value flop gives rx_q.
- Falling edge = rx_q & ~rx_s.

Tick generation:
- Counter runs 0..DIV-1 and wraps to 0. tick=1 for the single cycle where the count equals DIV-1.
- On a start detection the counter is forced to 0.

State machine (IDLE, START, DATA, STOP):
- IDLE: on a falling edge, go to START and clear the tick and sample counters. Without a new falling edge it stays in IDLE, so a held-low line is never accepted as a start.
- START: on each tick, sample_cnt++. On the tick where sample_cnt==7 (mid start bit):
  - rx_s=1 means a false start: return to IDLE with no pulse.
  - rx_s=0: set sample_cnt=0, bit index=0, go to DATA.
- DATA: on each tick, sample_cnt++ (4-bit, wraps). On the tick where sample_cnt==15:
  - shift rx_s into the MSB of the shift register, shifting right (LSB-first reassembly);
  - bit index++;
  - after DATA_BITS samples, go to STOP.
- STOP: on the tick where sample_cnt==15, go to IDLE immediately (mid stop bit) so back-to-back frames work.
  - rx_s=1: on the next clk, rx_data <= shift register and rx_valid <= 1.
  - If rx_valid was already 1 and rx_ack is low in that same cycle, pulse overrun. The new byte overwrites rx_data.
  - rx_s=0: pulse frame_err. rx_data and rx_valid are unchanged.

Handshake:
- rx_ack with rx_valid=1 clears rx_valid on the next clk.
- rx_ack with rx_valid=0 is ignored.
- Ack in the same cycle as a new byte landing: the new byte wins, rx_valid stays 1, and no overrun is flagged.

Latency:
- From the rx falling edge to rx_valid rising: 2-3 clk synchronizer/edge delay + (8 + 16*(DATA_BITS+1)) ticks + 1 clk.
- For DATA_BITS=8 that is 152 ticks (9.5 bit times).

Widths:
- Tick counter: $clog2(DIV) bits.
- Sample counter: 4 bits.
- Bit index: $clog2(DATA_BITS+1) bits.
- All compares are against width-cast constants.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - OVERSAMPLE=16;
  - START_SAMPLE=7;
  - BIT_SAMPLE=15;
  - default DATA_BITS=8.
- Sub-module uart_rx_tick_gen: parameters CLOCK_RATE and BAUD_RATE; ports clk, rst, clear; output tick. Shareable with a future transmitter.

Test Plan:
Bench parameters: CLOCK_RATE=1600000, BAUD_RATE=10000, so DIV=10 and one bit = 160 clk.
1. Send 0xA5 with a good stop bit -> rx_valid rises about 1522 clk after the start edge, rx_data=0xA5, no error pulses. Pulse rx_ack -> rx_valid=0 on the next clk.
2. Send 0x3C then 0xC3 back-to-back with no idle gap, acking each byte -> both bytes received in order, busy low for at most 1 bit between frames.
3. Low glitch of 40 clk on an idle line -> START aborts at the mid-start sample, busy returns to 0, no rx_valid and no frame_err.
4. Send 0x55 with the stop bit driven low -> frame_err pulses exactly 1 clk, rx_valid stays 0, rx_data unchanged.
5. Send 0x11 without ack, then 0x22 -> overrun pulses 1 clk, rx_data=0x22, rx_valid=1. Repeat with rx_ack asserted in the landing cycle -> no overrun.
6. Assert rst in the middle of DATA during 0xFF, release it, then send 0x81 -> all outputs return to reset values at once, and 0x81 is received correctly.
